slink_sync_fifo: RTL and testbench
==================================

# slink_sync_fifo

Single-clock, parametrised FIFO for S-Link datapaths where both sides share `clk`, such as the link-layer packet buffers and the app-side staging. It generalises the dual-clock FIFO:
- any depth from 2 to 256, not only powers of two;
- selectable first-word-fall-through (FWFT) or registered-read mode;
- occupancy count output;
- synchronous flush;
- optional sticky overflow/underflow error capture.

## Interface
Clock and reset: reset reset, asynchronous, active-high; clock clk.

Parameters:
- DATA_SIZE, 40, entry width in bits.
- DEPTH, 16, number of entries, 2..256, any integer.
- FWFT, 1: 1 = head entry presented on rdata whenever rempty=0; 0 = rdata registered on pop.
- LVL_SIZE, $clog2(DEPTH+1), width of level and threshold buses; derived, do not override.

Ports:
- clk  in  1  clock
- reset  in  1  async active-high reset
- flush  in  1  synchronous clear of pointers, level and flags
- winc  in  1  push request
- wdata  in  DATA_SIZE  push data
- rinc  in  1  pop request
- rdata  out  DATA_SIZE  read data
- wfull  out  1  level == DEPTH
- rempty  out  1  level == 0
- level  out  LVL_SIZE  current occupancy
- swi_almost_full  in  LVL_SIZE  almost-full threshold
- swi_almost_empty  in  LVL_SIZE  almost-empty threshold
- almost_full  out  1  level >= swi_almost_full
- almost_empty  out  1  level <= swi_almost_empty
- half_full  out  1  2*level >= DEPTH
- err_clear  in  1  clears sticky error bits
- overflow  out  1  sticky: push attempted while full
- underflow  out  1  sticky: pop attempted while empty

## Operation
- Push accepted when winc & ~wfull; write pointer advances.
- Pop accepted when rinc & ~rempty; read pointer advances.
- Pointers are binary 0..DEPTH-1 and wrap from DEPTH-1 to 0; no extra wrap bit. Full and empty are resolved by level.
- level update on each edge:
  - +1 on push only;
  - -1 on pop only;
  - unchanged on both or neither.
- Simultaneous push and pop:
  - when full: only the pop is accepted, because wfull strictly gates writes;
  - when empty: only the push is accepted; the pop is ignored.
- All flags (wfull, rempty, almost_*, half_full) are registered, computed from the next level, so they are coherent with level in the same cycle.
- Memory is a flop array with no reset and no clearing on flush.
- FWFT=1: rdata = mem[rptr], combinational from registered state; the value is undefined-but-stable while rempty=1.
- FWFT=0: rdata register loads mem[rptr] on an accepted pop and holds otherwise.
- flush:
  - next edge: level=0, pointers=0, all flags return to their reset values;
  - winc/rinc in the flush cycle are ignored;
  - rdata register (FWFT=0) is unchanged;
  - error bits are unaffected.
- Threshold outputs re-evaluate every cycle, so threshold inputs may change at any time.

## Timing
- Reset values:
  - level 0, rempty 1, wfull 0;
  - almost_empty 1, almost_full 0, half_full 0;
  - rdata 0 (FWFT=0), overflow 0, underflow 0.
- Push at edge N: level and flags reflect it in cycle N+1.
  - FWFT=1: rdata shows the pushed entry in cycle N+1 if the FIFO was empty.
- Pop at edge M:
  - FWFT=0: rdata holds the popped entry from cycle M+1;
  - FWFT=1: rdata advances to the next entry in cycle M+1.
- Back-to-back push/pop every cycle sustains throughput of 1 entry/cycle.
- Reset mid-operation: all state returns to reset values immediately. Memory contents are retained but are unreachable.

## Configuration
- SLINK_SYNC_FIFO_ERR_EN defined:
  - overflow sets on the edge after winc & wfull;
  - underflow sets on the edge after rinc & rempty;
  - both clear on err_clear; set wins over clear in the same cycle.
- Undefined: overflow and underflow are tied 0, err_clear is ignored, and no error flops are present.

## Test plan
- DEPTH=5, FWFT=1: push 0x01..0x05 on consecutive cycles -> wfull=1 and level=5 one cycle after the 5th push. A 6th push is dropped; popping 5 returns 0x01..0x05, then rempty=1.
- DEPTH=5: run 12 push/pop pairs with level held at 2 -> data order preserved across two pointer wraps, level stays 2, and flags never toggle.
- FWFT=0, DEPTH=16: push 0xA5, then pop one cycle later -> rdata=0xA5 in the cycle after the pop edge and holds until the next pop. Reset with rdata=0xA5 -> rdata=0.
- DEPTH=16, swi_almost_full=12, swi_almost_empty=3: fill to 16 -> almost_empty drops at level 4, half_full rises at 8, almost_full rises at 12, wfull rises at 16. Drain reverses each transition at the same levels.
- Full FIFO, winc=rinc=1 -> level 16->15 and the write is dropped. Empty FIFO, winc=rinc=1 -> level 0->1 and rempty=0 next cycle. Flush at level 9 with winc=1 -> level=0 and rempty=1 next cycle.
- With SLINK_SYNC_FIFO_ERR_EN: pop while empty -> underflow=1 next cycle. err_clear together with a new overflow event -> overflow=1 and underflow=0.

Source files
------------

// File: rtl/slink_sync_fifo.sv
// rtl/slink_sync_fifo.sv - single-clock FIFO, any depth 2..256, FWFT or registered read
// Sticky overflow/underflow capture is built only when SLINK_SYNC_FIFO_ERR_EN is defined.
module slink_sync_fifo #(
  parameter int DATA_SIZE = 40,
  parameter int DEPTH     = 16,
  parameter int FWFT      = 1,
  parameter int LVL_SIZE  = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 winc,
  input  logic [DATA_SIZE-1:0] wdata,
  input  logic                 rinc,
  output logic [DATA_SIZE-1:0] rdata,
  output logic                 wfull,
  output logic                 rempty,
  output logic [LVL_SIZE-1:0]  level,
  input  logic [LVL_SIZE-1:0]  swi_almost_full,
  input  logic [LVL_SIZE-1:0]  swi_almost_empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 half_full,
  input  logic                 err_clear,
  output logic                 overflow,
  output logic                 underflow
);
  localparam int PTR_SIZE = $clog2(DEPTH);
  localparam logic [PTR_SIZE-1:0] PTR_LAST  = PTR_SIZE'(DEPTH - 1);
  localparam logic [LVL_SIZE-1:0] LVL_FULL  = LVL_SIZE'(DEPTH);
  localparam logic [LVL_SIZE:0]   HALF_MARK = (LVL_SIZE + 1)'(DEPTH);

  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [PTR_SIZE-1:0]  wptr;
  logic [PTR_SIZE-1:0]  rptr;
  logic                 push;
  logic                 pop;
  logic [LVL_SIZE-1:0]  level_nxt;
  logic [LVL_SIZE:0]    level_dbl;

  // Full and empty come from the registered level, so these gates never see a stale pointer compare.
  assign push = winc & ~wfull & ~flush;
  assign pop  = rinc & ~rempty & ~flush;

  function automatic logic [PTR_SIZE-1:0] ptr_inc(input logic [PTR_SIZE-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_SIZE'(1);
  endfunction

  always_comb begin
    level_nxt = level;
    if (push && !pop) begin
      level_nxt = level + LVL_SIZE'(1);
    end else if (pop && !push) begin
      level_nxt = level - LVL_SIZE'(1);
    end
  end

  assign level_dbl = {level_nxt, 1'b0};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr         <= '0;
      rptr         <= '0;
      level        <= '0;
      wfull        <= 1'b0;
      rempty       <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      half_full    <= 1'b0;
    end else if (flush) begin
      wptr         <= '0;
      rptr         <= '0;
      level        <= '0;
      wfull        <= 1'b0;
      rempty       <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      half_full    <= 1'b0;
    end else begin
      if (push) begin
        wptr <= ptr_inc(wptr);
      end
      if (pop) begin
        rptr <= ptr_inc(rptr);
      end
      level        <= level_nxt;
      wfull        <= (level_nxt == LVL_FULL);
      rempty       <= (level_nxt == '0);
      almost_full  <= (level_nxt >= swi_almost_full);
      almost_empty <= (level_nxt <= swi_almost_empty);
      half_full    <= (level_dbl >= HALF_MARK);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= wdata;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rdata = mem[rptr];
    end else begin : g_reg_read
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rdata <= '0;
        end else if (pop) begin
          rdata <= mem[rptr];
        end
      end
    end
  endgenerate

`ifdef SLINK_SYNC_FIFO_ERR_EN
  logic ovf_q;
  logic udf_q;

  // A new event in the same cycle as err_clear keeps its bit set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= (ovf_q & ~err_clear) | (winc & wfull & ~flush);
      udf_q <= (udf_q & ~err_clear) | (rinc & rempty & ~flush);
    end
  end

  assign overflow  = ovf_q;
  assign underflow = udf_q;
`else
  logic unused_err_clear;

  assign unused_err_clear = err_clear;
  assign overflow         = 1'b0;
  assign underflow        = 1'b0;
`endif

endmodule

// File: tb/tb_slink_sync_fifo.sv
// tb/tb_slink_sync_fifo.sv - bench for slink_sync_fifo: DEPTH=5/16 FWFT, DEPTH=16 registered read
module tb_slink_sync_fifo;
  localparam int DW = 40;
`ifdef SLINK_SYNC_FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, flush, winc, rinc, err_clear;
  logic [DW-1:0] wdata;
  logic [2:0]    af5, ae5;
  logic [4:0]    af16, ae16;

  logic [DW-1:0] rdata_a, rdata_b, rdata_c;
  logic [2:0]    lvl_a;
  logic [4:0]    lvl_b, lvl_c;
  logic wfull_a, rempty_a, af_a, ae_a, hf_a, ovf_a, udf_a;
  logic wfull_b, rempty_b, af_b, ae_b, hf_b, ovf_b, udf_b;
  logic wfull_c, rempty_c, af_c, ae_c, hf_c, ovf_c, udf_c;

  slink_sync_fifo #(.DATA_SIZE(DW), .DEPTH(5), .FWFT(1)) u_a (
    .clk(clk), .reset(reset), .flush(flush), .winc(winc), .wdata(wdata), .rinc(rinc),
    .rdata(rdata_a), .wfull(wfull_a), .rempty(rempty_a), .level(lvl_a),
    .swi_almost_full(af5), .swi_almost_empty(ae5), .almost_full(af_a), .almost_empty(ae_a),
    .half_full(hf_a), .err_clear(err_clear), .overflow(ovf_a), .underflow(udf_a));

  slink_sync_fifo #(.DATA_SIZE(DW), .DEPTH(16), .FWFT(1)) u_b (
    .clk(clk), .reset(reset), .flush(flush), .winc(winc), .wdata(wdata), .rinc(rinc),
    .rdata(rdata_b), .wfull(wfull_b), .rempty(rempty_b), .level(lvl_b),
    .swi_almost_full(af16), .swi_almost_empty(ae16), .almost_full(af_b), .almost_empty(ae_b),
    .half_full(hf_b), .err_clear(err_clear), .overflow(ovf_b), .underflow(udf_b));

  slink_sync_fifo #(.DATA_SIZE(DW), .DEPTH(16), .FWFT(0)) u_c (
    .clk(clk), .reset(reset), .flush(flush), .winc(winc), .wdata(wdata), .rinc(rinc),
    .rdata(rdata_c), .wfull(wfull_c), .rempty(rempty_c), .level(lvl_c),
    .swi_almost_full(af16), .swi_almost_empty(ae16), .almost_full(af_c), .almost_empty(ae_c),
    .half_full(hf_c), .err_clear(err_clear), .overflow(ovf_c), .underflow(udf_c));

  // Reference: per-instance ordered list, index 0 is the oldest entry.
  int            mdep [3];
  bit            mfw  [3];
  int            mcnt [3];
  logic [DW-1:0] mdat [3][16];
  logic [DW-1:0] mrd  [3];
  bit            movf [3], mudf [3], maf [3], mae [3], mhf [3];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit         w;
    bit         r;
    logic [7:0] d;
    int         lvl;
    bit         full;
    bit         empty;
    bit         chk_rd;
    logic [7:0] head;
  } vec_t;
  vec_t tv [12];

  task automatic chk(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst=%0d t=%0t got=%0h expected=%0h", name, inst, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mcnt[i] = 0; mrd[i] = '0; movf[i] = 0; mudf[i] = 0;
      maf[i] = 0; mae[i] = 1; mhf[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      bit full, empty, evo, evu;
      int taf, tae;
      taf   = (i == 0) ? int'(af5) : int'(af16);
      tae   = (i == 0) ? int'(ae5) : int'(ae16);
      full  = (mcnt[i] == mdep[i]);
      empty = (mcnt[i] == 0);
      evo   = winc && full && !flush;
      evu   = rinc && empty && !flush;
      if (ERR_EN) begin
        movf[i] = (movf[i] && !err_clear) || evo;
        mudf[i] = (mudf[i] && !err_clear) || evu;
      end
      if (flush) begin
        mcnt[i] = 0; maf[i] = 0; mae[i] = 1; mhf[i] = 0;
      end else begin
        if (rinc && !empty) begin
          if (!mfw[i]) mrd[i] = mdat[i][0];
          for (int k = 0; k < 15; k++) mdat[i][k] = mdat[i][k+1];
          mcnt[i]--;
        end
        if (winc && !full) begin
          mdat[i][mcnt[i]] = wdata;
          mcnt[i]++;
        end
        maf[i] = (mcnt[i] >= taf);
        mae[i] = (mcnt[i] <= tae);
        mhf[i] = (2 * mcnt[i] >= mdep[i]);
      end
    end
  endtask

  task automatic check_inst(input int i);
    logic [63:0]   lv;
    logic          wf, re, afo, aeo, hfo, ov, un;
    logic [DW-1:0] rd;
    case (i)
      0:       begin lv = 64'(lvl_a); wf = wfull_a; re = rempty_a; afo = af_a; aeo = ae_a;
                     hfo = hf_a; ov = ovf_a; un = udf_a; rd = rdata_a; end
      1:       begin lv = 64'(lvl_b); wf = wfull_b; re = rempty_b; afo = af_b; aeo = ae_b;
                     hfo = hf_b; ov = ovf_b; un = udf_b; rd = rdata_b; end
      default: begin lv = 64'(lvl_c); wf = wfull_c; re = rempty_c; afo = af_c; aeo = ae_c;
                     hfo = hf_c; ov = ovf_c; un = udf_c; rd = rdata_c; end
    endcase
    chk("level", i, lv, 64'(mcnt[i]));
    chk("wfull", i, 64'(wf), 64'(mcnt[i] == mdep[i]));
    chk("rempty", i, 64'(re), 64'(mcnt[i] == 0));
    chk("almost_full", i, 64'(afo), 64'(maf[i]));
    chk("almost_empty", i, 64'(aeo), 64'(mae[i]));
    chk("half_full", i, 64'(hfo), 64'(mhf[i]));
    chk("overflow", i, 64'(ov), 64'(movf[i]));
    chk("underflow", i, 64'(un), 64'(mudf[i]));
    if (!mfw[i]) chk("rdata_reg", i, 64'(rd), 64'(mrd[i]));
    else if (mcnt[i] > 0) chk("rdata_head", i, 64'(rd), 64'(mdat[i][0]));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) check_inst(i);
  endtask

  task automatic step(input bit f, input bit w, input bit r, input logic [DW-1:0] d, input bit ec);
    flush = f; winc = w; rinc = r; wdata = d; err_clear = ec;
    cycle();
  endtask

  initial begin
    mdep = '{5, 16, 16};
    mfw  = '{1, 1, 0};
    reset = 1'b1; flush = 0; winc = 0; rinc = 0; err_clear = 0; wdata = '0;
    af5 = 3'd4; ae5 = 3'd1; af16 = 5'd12; ae16 = 5'd3;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level", 0, 64'(lvl_a), 64'd0);
    chk("rst_rempty", 0, 64'(rempty_a), 64'd1);
    chk("rst_wfull", 0, 64'(wfull_a), 64'd0);
    chk("rst_almost_empty", 1, 64'(ae_b), 64'd1);
    chk("rst_almost_full", 1, 64'(af_b), 64'd0);
    chk("rst_half_full", 1, 64'(hf_b), 64'd0);
    chk("rst_rdata", 2, 64'(rdata_c), 64'd0);
    chk("rst_overflow", 2, 64'(ovf_c), 64'd0);
    chk("rst_underflow", 2, 64'(udf_c), 64'd0);
    reset = 1'b0;

    // DEPTH=5: five pushes fill it, a sixth is dropped, five pops drain in order, one more underflows
    for (int i = 1; i <= 5; i++) tv[i-1] = '{1'b1, 1'b0, 8'(i), i, (i == 5), 1'b0, 1'b1, 8'h01};
    tv[5] = '{1'b1, 1'b0, 8'h06, 5, 1'b1, 1'b0, 1'b1, 8'h01};
    for (int k = 1; k <= 4; k++) tv[5+k] = '{1'b0, 1'b1, 8'h00, 5 - k, 1'b0, 1'b0, 1'b1, 8'(k + 1)};
    tv[10] = '{1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1, 1'b0, 8'h00};
    tv[11] = '{1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1, 1'b0, 8'h00};
    for (int i = 0; i < 12; i++) begin
      step(0, tv[i].w, tv[i].r, DW'(tv[i].d), 0);
      chk("tbl_level", i, 64'(lvl_a), 64'(tv[i].lvl));
      chk("tbl_wfull", i, 64'(wfull_a), 64'(tv[i].full));
      chk("tbl_rempty", i, 64'(rempty_a), 64'(tv[i].empty));
      if (tv[i].chk_rd) chk("tbl_rdata", i, 64'(rdata_a), 64'(tv[i].head));
    end

    // DEPTH=5 held at level 2 across two pointer wraps
    step(0, 1, 0, DW'(8'h10), 0);
    step(0, 1, 0, DW'(8'h11), 0);
    for (int j = 0; j < 12; j++) begin
      step(0, 1, 1, DW'(8'h12 + j), 0);
      chk("wrap_level", j, 64'(lvl_a), 64'd2);
      chk("wrap_head", j, 64'(rdata_a), 64'(8'h11 + j));
      chk("wrap_flags", j, 64'({wfull_a, rempty_a, af_a, ae_a, hf_a}), 64'd0);
    end
    step(1, 0, 0, '0, 0);

    // Registered read: pop returns A5 the next cycle and holds; async reset clears it
    step(0, 1, 0, DW'(8'hA5), 0);
    step(0, 0, 1, '0, 0);
    chk("reg_rdata_pop", 2, 64'(rdata_c), 64'hA5);
    for (int j = 0; j < 3; j++) begin
      step(0, 0, 0, '0, 0);
      chk("reg_rdata_hold", 2, 64'(rdata_c), 64'hA5);
    end
    step(0, 1, 0, DW'(8'h33), 0);
    winc = 0;
    reset = 1'b1;
    #2;
    chk("async_rst_rdata", 2, 64'(rdata_c), 64'd0);
    chk("async_rst_level", 2, 64'(lvl_c), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) check_inst(i);
    reset = 1'b0;

    // DEPTH=16 threshold walk with almost_full=12, almost_empty=3
    for (int k = 1; k <= 16; k++) begin
      step(0, 1, 0, DW'(12'h100 + k), 0);
      chk("fill_ae", k, 64'(ae_b), 64'(k <= 3));
      chk("fill_hf", k, 64'(hf_b), 64'(k >= 8));
      chk("fill_af", k, 64'(af_b), 64'(k >= 12));
      chk("fill_wfull", k, 64'(wfull_b), 64'(k == 16));
    end
    step(0, 1, 1, DW'(12'hBAD), 0);
    chk("full_both_level", 1, 64'(lvl_b), 64'd15);
    chk("full_both_head", 1, 64'(rdata_b), 64'h102);
    for (int k = 14; k >= 0; k--) begin
      step(0, 0, 1, '0, 0);
      chk("drain_ae", k, 64'(ae_b), 64'(k <= 3));
      chk("drain_hf", k, 64'(hf_b), 64'(k >= 8));
      chk("drain_af", k, 64'(af_b), 64'(k >= 12));
      chk("drain_rempty", k, 64'(rempty_b), 64'(k == 0));
    end
    step(0, 1, 1, DW'(8'h77), 0);
    chk("empty_both_level", 1, 64'(lvl_b), 64'd1);
    chk("empty_both_rempty", 1, 64'(rempty_b), 64'd0);
    for (int k = 0; k < 8; k++) step(0, 1, 0, DW'(k), 0);
    chk("pre_flush_level", 1, 64'(lvl_b), 64'd9);
    step(1, 1, 0, DW'(8'h99), 0);
    chk("flush_level", 1, 64'(lvl_b), 64'd0);
    chk("flush_rempty", 1, 64'(rempty_b), 64'd1);

    // Sticky error capture
    step(0, 0, 0, '0, 1);
    step(0, 0, 1, '0, 0);
    chk("underflow_on_empty_pop", 0, 64'(udf_a), 64'(ERR_EN));
    for (int k = 0; k < 5; k++) step(0, 1, 0, DW'(k), 0);
    step(0, 1, 0, DW'(8'h55), 1);
    chk("overflow_set_wins", 0, 64'(ovf_a), 64'(ERR_EN));
    chk("underflow_cleared", 0, 64'(udf_a), 64'd0);
    step(1, 0, 0, '0, 0);

    // Random traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      int wp, rp;
      bit f, w, r, ec;
      case ((n / 200) % 4)
        0:       begin wp = 80; rp = 20; end
        1:       begin wp = 20; rp = 80; end
        2:       begin wp = 50; rp = 50; end
        default: begin wp = 95; rp = 95; end
      endcase
      f  = ($urandom_range(0, 99) == 0);
      w  = !f && ($urandom_range(0, 99) < wp);
      r  = !f && ($urandom_range(0, 99) < rp);
      ec = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 49) == 0) begin
        af5 = 3'($urandom); ae5 = 3'($urandom);
        af16 = 5'($urandom_range(0, 16)); ae16 = 5'($urandom_range(0, 16));
      end
      step(f, w, r, {8'($urandom), 32'($urandom)}, ec);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
